// File: rtl/apu_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apu_serial_pkg
//  Description : Shared constants for the APU bit-serial arithmetic blocks.
//                It holds the controller state encoding and the opcode values.
//  Revision    : 1.0 - initial release
// ============================================================================
package apu_serial_pkg;

  // Controller state encoding. The width is fixed and explicit.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Operation select as it is sampled on the subtract input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : apu_serial_pkg
`default_nettype wire

// File: rtl/FullAdder.sv
`default_nettype none
// ============================================================================
//  Module      : FullAdder
//  Description : Single-bit full adder. This is the slice that the
//                bit-serial controller reuses on every clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module FullAdder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  // Sum and majority carry.
  always_comb begin
    sum_o   = a_i ^ b_i ^ c_i;
    carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  end

endmodule : FullAdder
`default_nettype wire

// File: rtl/bit_serial_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serial_add_sub
//  Description : WIDTH-bit two's-complement add/subtract. One shared
//                FullAdder processes one bit per clock, LSB first, and the
//                block uses a start/ready/done handshake.
//                Subtract is computed as opA + ~opB + 1: the carry flop is
//                preset to 1 when the operands are loaded.
//                Result, carryOut and overflow are loaded on the RUN->DONE
//                edge. They are therefore valid in the same cycle that done
//                is high, and they hold until the next operation reaches
//                DONE. Overflow is the carry into the MSB XOR the carry out
//                of the MSB. Both carries are available during the last RUN
//                cycle, so no separate prevCarry flop is needed.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_add_sub
  import apu_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             overflow
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-2:0]  acc_q;
  logic              carry_q;
  logic [CW-1:0]     count_q;
  logic [WIDTH-1:0]  result_q;
  logic              carry_out_q;
  logic              overflow_q;

  logic              fa_sum;
  logic              fa_cout;
  logic [WIDTH-1:0]  acc_full;
  logic              last_bit;

  // Shared bit slice. It is fed from the LSBs of the operand shifters and the carry flop.
  FullAdder u_fa (
    .a_i     (a_q[0]),
    .b_i     (b_q[0]),
    .c_i     (carry_q),
    .sum_o   (fa_sum),
    .carry_o (fa_cout)
  );

  // The new sum bit enters at the MSB. After the last bit this value is the full result.
  assign acc_full = {fa_sum, acc_q};
  assign last_bit = (count_q == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Start is honoured only in IDLE, and DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs, decoded from the state only.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      RUN:     busy  = 1'b1;
      DONE:    done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Datapath: operands are captured at start, shifted once per RUN cycle, and the result is loaded on the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= opA;
            b_q     <= (subtract == OP_SUB) ? ~opB : opB;
            carry_q <= subtract;
            count_q <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          acc_q   <= acc_full[WIDTH-1:1];
          carry_q <= fa_cout;
          if (last_bit) begin
            result_q    <= acc_full;
            carry_out_q <= fa_cout;
            overflow_q  <= carry_q ^ fa_cout;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        default: begin
          // DONE keeps every datapath register unchanged.
        end
      endcase
    end
  end

  assign result   = result_q;
  assign carryOut = carry_out_q;
  assign overflow = overflow_q;

endmodule : bit_serial_add_sub
`default_nettype wire

// File: tb/tb_bit_serial_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_serial_add_sub
//  Description : Directed and random checks of bit_serial_add_sub at
//                WIDTH=8. Expected values go into a queue when an operation
//                starts and are taken out when done is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serial_add_sub;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         subtract;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carryOut;
  logic         overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  bit_serial_add_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .subtract (subtract),
    .opA      (opA),
    .opB      (opB),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carryOut (carryOut),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model. It uses the plain integer sum and the operand/result sign rule for overflow.
  function automatic exp_t model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   ai;
    int   bi;
    int   s;
    ai = int'(a);
    bi = int'(b);
    if (sub) s = ai - bi + 256;
    else     s = ai + bi;
    e.res = s[W-1:0];
    e.co  = (s >= 256);
    if (sub) e.ov = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
    else     e.ov = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
    return e;
  endfunction

  // Runs one operation from the cycle where start is driven (cycle 0). With
  // noise set, start is pulsed again at cycles 3 and 9 with other operands.
  task automatic do_op(input string tag, input logic sub, input logic [W-1:0] a,
                       input logic [W-1:0] b, input exp_t e, input bit noise);
    int   n;
    bit   seen;
    exp_t got;
    n    = 0;
    seen = 0;
    sb_q.push_back(e);
    @(negedge clk);
    chk({tag, "_ready_pre"}, ready, 1'b1);
    start    = 1'b1;
    subtract = sub;
    opA      = a;
    opB      = b;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      start = noise && (n == 3 || n == 9);
      if (start) begin
        subtract = 1'b1;
        opA      = 8'hC3;
        opB      = 8'h5E;
      end
      if (n == 1) begin
        chk({tag, "_busy_c1"}, {ready, busy, done}, 3'b010);
      end
      if (done) seen = 1;
    end
    if (!seen) begin
      chk({tag, "_done_timeout"}, 1'b0, 1'b1);
      void'(sb_q.pop_front());
    end else begin
      got = sb_q.pop_front();
      chk({tag, "_latency"}, 64'(n), 64'(W + 1));
      chk({tag, "_result"}, result, got.res);
      chk({tag, "_flags"}, {carryOut, overflow}, {got.co, got.ov});
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_after"}, {ready, busy, done}, 3'b100);
      chk({tag, "_hold"}, {result, carryOut, overflow}, {got.res, got.co, got.ov});
    end
  endtask

  initial begin : stim
    int   dn;
    exp_t e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    reset    = 1'b1;
    start    = 1'b0;
    subtract = 1'b0;
    opA      = '0;
    opB      = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {ready, busy, done, result, carryOut, overflow}, {3'b100, 8'h00, 2'b00});
    reset = 1'b0;

    do_op("add_5a_33", 1'b0, 8'h5A, 8'h33, '{res: 8'h8D, co: 1'b0, ov: 1'b1}, 1'b0);
    do_op("add_ff_01", 1'b0, 8'hFF, 8'h01, '{res: 8'h00, co: 1'b1, ov: 1'b0}, 1'b0);
    do_op("sub_10_20", 1'b1, 8'h10, 8'h20, '{res: 8'hF0, co: 1'b0, ov: 1'b0}, 1'b0);
    do_op("sub_80_01", 1'b1, 8'h80, 8'h01, '{res: 8'h7F, co: 1'b1, ov: 1'b1}, 1'b0);
    do_op("ignore_start", 1'b0, 8'h01, 8'h01, '{res: 8'h02, co: 1'b0, ov: 1'b0}, 1'b1);

    // Start pulses that are ignored must not lead to a second operation.
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("ignore_no_extra_done", 64'(dn), 64'd0);

    // An operation aborted by reset: the bench pushes no expectation for it and checks that done never pulses.
    @(negedge clk);
    start    = 1'b1;
    subtract = 1'b0;
    opA      = 8'h5A;
    opB      = 8'h33;
    dn       = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dn++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_state", {ready, busy, done, result, carryOut, overflow}, {3'b100, 8'h00, 2'b00});
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    do_op("after_abort", 1'b0, 8'h03, 8'h04, '{res: 8'h07, co: 1'b0, ov: 1'b0}, 1'b0);

    // Random operations, checked against the reference model.
    for (int k = 0; k < 6; k++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      e  = model(rs, ra, rb);
      do_op("rand", rs, ra, rb, e, 1'b0);
    end

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bit_serial_add_sub
`default_nettype wire
